spi_disp_ctrl: RTL and testbench

Command sequencer between the SPI slave byte interface and the 4-digit 7-segment driver on the Pi fan FPGA. Parses framed command bytes from the SPI receive strobe and owns the BCD digit and colon registers feeding the display driver. Loads a response byte into the SPI transmit path after every received byte. Counts BCD up on command or, optionally, from the 1 s tick.

---
 rtl/spi_disp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_disp_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_disp_ctrl.sv
// SPI command sequencer owning the 4-digit BCD display and colon registers.
// Optional tick-driven auto-count is compiled in with DISP_CTRL_AUTOCOUNT_EN.
module spi_disp_ctrl #(
   parameter logic [7:0] ERR_SAT = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_cs_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       tx_load,
   output logic [7:0] tx_byte,
   input  logic       tick_1s,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [1:0] colon,
   output logic [7:0] err_count
);

   typedef enum logic [2:0] {IDLE, CMD, WR_HI, WR_LO, RD_HI, RD_LO} state_t;

   state_t      state;
   logic        cs_prev;
   logic [7:0]  hold;
   logic        auto_en;

   logic        cs_fall;
   logic        take;
   logic        in_cmd;
   logic        wr_lo;
   logic        wr_bad;
   logic        cmd_legal;
   logic        cmd_inc;
   logic        tick_inc;
   logic        err_inc;
   logic [7:0]  status;
   logic [15:0] cur_digits;
   logic [15:0] inc_digits;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] sat9(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   // A byte is only consumed inside a frame; the falling edge itself may carry the command byte.
   always_comb begin
      cs_fall    = cs_prev & ~spi_cs_n;
      take       = rx_valid & ~spi_cs_n & ((state != IDLE) | cs_fall);
      in_cmd     = take & ((state == CMD) | (state == IDLE));
      wr_lo      = take & (state == WR_LO);
      wr_bad     = (hold[7:4] > 4'd9) | (hold[3:0] > 4'd9) |
                   (rx_byte[7:4] > 4'd9) | (rx_byte[3:0] > 4'd9);
      cmd_legal  = 1'b0;
      case (rx_byte)
         8'h00, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h40: cmd_legal = 1'b1;
`ifdef DISP_CTRL_AUTOCOUNT_EN
         8'h50, 8'h51: cmd_legal = 1'b1;
`endif
         default: cmd_legal = 1'b0;
      endcase
      cmd_inc    = in_cmd & (rx_byte == 8'h30);
      tick_inc   = auto_en & tick_1s & ~cmd_inc & ~wr_lo;
      err_inc    = (in_cmd & ~cmd_legal) | (wr_lo & wr_bad);
      status     = {auto_en, 1'b0, colon, err_count[3:0]};
      cur_digits = {digit3, digit2, digit1, digit0};
      inc_digits = bcd_inc(cur_digits);
   end

`ifndef DISP_CTRL_AUTOCOUNT_EN
   assign auto_en = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cs_prev   <= 1'b0;
         hold      <= 8'h00;
         tx_load   <= 1'b0;
         tx_byte   <= 8'h00;
         digit0    <= 4'd0;
         digit1    <= 4'd0;
         digit2    <= 4'd0;
         digit3    <= 4'd0;
         colon     <= 2'b11;
         err_count <= 8'h00;
`ifdef DISP_CTRL_AUTOCOUNT_EN
         auto_en   <= 1'b0;
`endif
      end else begin
         cs_prev <= spi_cs_n;
         tx_load <= 1'b0;

         if (spi_cs_n) begin
            state <= IDLE;
         end else if (take) begin
            tx_load <= 1'b1;
            tx_byte <= status;
            case (state)
               IDLE, CMD: begin
                  state <= CMD;
                  case (rx_byte)
                     8'h10: state <= WR_HI;
                     8'h20, 8'h21, 8'h22, 8'h23: colon <= rx_byte[1:0];
                     8'h40: begin
                        state   <= RD_HI;
                        tx_byte <= {digit3, digit2};
                     end
`ifdef DISP_CTRL_AUTOCOUNT_EN
                     8'h50: auto_en <= 1'b0;
                     8'h51: auto_en <= 1'b1;
`endif
                     default: ;
                  endcase
               end
               WR_HI: begin
                  hold  <= rx_byte;
                  state <= WR_LO;
               end
               WR_LO: begin
                  digit3 <= sat9(hold[7:4]);
                  digit2 <= sat9(hold[3:0]);
                  digit1 <= sat9(rx_byte[7:4]);
                  digit0 <= sat9(rx_byte[3:0]);
                  state  <= CMD;
               end
               RD_HI: begin
                  tx_byte <= {digit1, digit0};
                  state   <= RD_LO;
               end
               RD_LO:   state <= CMD;
               default: state <= IDLE;
            endcase
         end

         // Never coincides with a WR_LO load: tick_inc is masked and cmd_inc is CMD-only.
         if (cmd_inc | tick_inc) begin
            {digit3, digit2, digit1, digit0} <= inc_digits;
         end

         if (err_inc && (err_count != ERR_SAT)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_disp_ctrl.sv
// Directed bench for spi_disp_ctrl: per-cycle vector table plus multi-cycle corner sequences.
module tb_spi_disp_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_cs_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        tick_1s;
   logic        tx_load;
   logic [7:0]  tx_byte;
   logic [3:0]  digit0, digit1, digit2, digit3;
   logic [1:0]  colon;
   logic [7:0]  err_count;
   logic [15:0] digits;

   int checks = 0;
   int errors = 0;

   assign digits = {digit3, digit2, digit1, digit0};

   spi_disp_ctrl #(.ERR_SAT(8'hFF)) dut (
      .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .tx_load(tx_load), .tx_byte(tx_byte), .tick_1s(tick_1s),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .colon(colon), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cs;
      logic        vld;
      logic [7:0]  b;
      logic        ld;
      logic [7:0]  tx;
      logic [15:0] dig;
      logic [1:0]  col;
      logic [7:0]  err;
   } vec_t;

   vec_t vecs[32];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, return at the next falling edge with the posedge result visible.
   task automatic step(input logic cs, input logic v, input logic [7:0] b);
      spi_cs_n = cs;
      rx_valid = v;
      rx_byte  = b;
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic cs, input logic v, input logic [7:0] b, input logic ld,
                               input logic [7:0] tx, input logic [15:0] dig, input logic [1:0] col,
                               input logic [7:0] err);
      vec_t r;
      r.cs = cs; r.vld = v; r.b = b; r.ld = ld; r.tx = tx; r.dig = dig; r.col = col; r.err = err;
      return r;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads;

      vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b11, 8'h00);
      vecs[1]  = mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h30, 16'h0000, 2'b11, 8'h00);
      vecs[2]  = mk(1'b0, 1'b1, 8'h12, 1'b1, 8'h30, 16'h0000, 2'b11, 8'h00);
      vecs[3]  = mk(1'b0, 1'b1, 8'h34, 1'b1, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[6]  = mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[7]  = mk(1'b0, 1'b1, 8'h12, 1'b1, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[8]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[9]  = mk(1'b1, 1'b1, 8'h56, 1'b0, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[10] = mk(1'b0, 1'b1, 8'h00, 1'b1, 8'h30, 16'h1234, 2'b11, 8'h00);
      vecs[11] = mk(1'b0, 1'b1, 8'h34, 1'b1, 8'h30, 16'h1234, 2'b11, 8'h01);
      vecs[12] = mk(1'b0, 1'b1, 8'h22, 1'b1, 8'h31, 16'h1234, 2'b10, 8'h01);
      vecs[13] = mk(1'b0, 1'b1, 8'h30, 1'b1, 8'h21, 16'h1235, 2'b10, 8'h01);
      vecs[14] = mk(1'b0, 1'b1, 8'h40, 1'b1, 8'h12, 16'h1235, 2'b10, 8'h01);
      vecs[15] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 8'h35, 16'h1235, 2'b10, 8'h01);
      vecs[16] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 8'h21, 16'h1235, 2'b10, 8'h01);
      vecs[17] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 8'h21, 16'h1235, 2'b10, 8'h02);
      vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h21, 16'h1235, 2'b10, 8'h02);
      vecs[19] = mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h22, 16'h1235, 2'b10, 8'h02);
      vecs[20] = mk(1'b0, 1'b1, 8'h99, 1'b1, 8'h22, 16'h1235, 2'b10, 8'h02);
      vecs[21] = mk(1'b0, 1'b1, 8'h99, 1'b1, 8'h22, 16'h9999, 2'b10, 8'h02);
      vecs[22] = mk(1'b0, 1'b1, 8'h30, 1'b1, 8'h22, 16'h0000, 2'b10, 8'h02);
      vecs[23] = mk(1'b0, 1'b1, 8'h40, 1'b1, 8'h00, 16'h0000, 2'b10, 8'h02);
      vecs[24] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 16'h0000, 2'b10, 8'h02);
      vecs[25] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 8'h22, 16'h0000, 2'b10, 8'h02);
      vecs[26] = mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h22, 16'h0000, 2'b10, 8'h02);
      vecs[27] = mk(1'b0, 1'b1, 8'hAB, 1'b1, 8'h22, 16'h0000, 2'b10, 8'h02);
      vecs[28] = mk(1'b0, 1'b1, 8'h12, 1'b1, 8'h22, 16'h9912, 2'b10, 8'h03);
      vecs[29] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 16'h9912, 2'b10, 8'h03);
      vecs[30] = mk(1'b0, 1'b1, 8'h21, 1'b1, 8'h23, 16'h9912, 2'b01, 8'h03);
      vecs[31] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h23, 16'h9912, 2'b01, 8'h03);

      reset    = 1'b1;
      spi_cs_n = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      tick_1s  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_digits", digits, 16'h0000);
      check("rst_colon", 16'(colon), 16'h0003);
      check("rst_tx_byte", 16'(tx_byte), 16'h0000);
      check("rst_tx_load", 16'(tx_load), 16'h0000);
      check("rst_err", 16'(err_count), 16'h0000);
      reset = 1'b0;

      for (int i = 0; i < 32; i++) begin
         step(vecs[i].cs, vecs[i].vld, vecs[i].b);
         check($sformatf("v%0d_tx_load", i), 16'(tx_load), 16'(vecs[i].ld));
         check($sformatf("v%0d_tx_byte", i), 16'(tx_byte), 16'(vecs[i].tx));
         check($sformatf("v%0d_digits", i), digits, vecs[i].dig);
         check($sformatf("v%0d_colon", i), 16'(colon), 16'(vecs[i].col));
         check($sformatf("v%0d_err", i), 16'(err_count), 16'(vecs[i].err));
      end

      // Error counter saturation over a long back-to-back burst of illegal bytes.
      loads = 0;
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b1, 8'h77);
         if (tx_load) loads++;
      end
      step(1'b1, 1'b0, 8'h00);
      check("sat_err", 16'(err_count), 16'h00FF);
      check("sat_loads", 16'(loads), 16'd300);
      check("sat_digits", digits, 16'h9912);

      // Reset in the middle of a frame abandons it until the next chip-select fall.
      step(1'b0, 1'b1, 8'h22);
      check("mid_colon_set", 16'(colon), 16'h0002);
      reset = 1'b1;
      step(1'b0, 1'b1, 8'h20);
      check("mid_rst_colon", 16'(colon), 16'h0003);
      check("mid_rst_digits", digits, 16'h0000);
      check("mid_rst_err", 16'(err_count), 16'h0000);
      check("mid_rst_tx_byte", 16'(tx_byte), 16'h0000);
      check("mid_rst_tx_load", 16'(tx_load), 16'h0000);
      reset = 1'b0;
      step(1'b0, 1'b1, 8'h20);
      check("abandon_ld0", 16'(tx_load), 16'h0000);
      step(1'b0, 1'b1, 8'h23);
      check("abandon_ld1", 16'(tx_load), 16'h0000);
      check("abandon_colon", 16'(colon), 16'h0003);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h20);
      check("new_frame_ld", 16'(tx_load), 16'h0001);
      check("new_frame_tx", 16'(tx_byte), 16'h0030);
      check("new_frame_colon", 16'(colon), 16'h0000);
      step(1'b1, 1'b0, 8'h00);

`ifdef DISP_CTRL_AUTOCOUNT_EN
      step(1'b0, 1'b1, 8'h51);
      check("auto_on_tx", 16'(tx_byte), 16'h0000);
      step(1'b0, 1'b1, 8'h00);
      check("auto_status", 16'(tx_byte), 16'h0080);
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick_1s = 1'b1;
         step(1'b1, 1'b0, 8'h00);
         tick_1s = 1'b0;
         step(1'b1, 1'b0, 8'h00);
      end
      check("auto_ticks", digits, 16'h0003);
      step(1'b0, 1'b1, 8'h10);
      step(1'b0, 1'b1, 8'h00);
      tick_1s = 1'b1;
      step(1'b0, 1'b1, 8'h50);
      tick_1s = 1'b0;
      check("tick_vs_write", digits, 16'h0050);
      step(1'b1, 1'b0, 8'h00);
      check("tick_vs_write_hold", digits, 16'h0050);
`else
      tick_1s = 1'b1;
      step(1'b1, 1'b0, 8'h00);
      tick_1s = 1'b0;
      check("tick_ignored", digits, 16'h0000);
      step(1'b0, 1'b1, 8'h51);
      check("cmd51_illegal", 16'(err_count), 16'h0001);
      step(1'b0, 1'b1, 8'h00);
      check("auto_bit_zero", 16'(tx_byte), 16'h0001);
      step(1'b1, 1'b0, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
